// File: rtl/ring_ctrl.sv
// Multi-channel alarm ringer with on/off cadence, request queueing and optional snooze (RING_SNOOZE_EN).
// One cycle from trig edge to loud; no backpressure, overlapping requests wait in pending.
module ring_ctrl #(
  parameter int NCH          = 2,
  parameter int CNT_W        = 8,
  parameter int DURATION     = 4,
  parameter int ON_TICKS     = 4,
  parameter int OFF_TICKS    = 0,
  parameter int SNOOZE_TICKS = 8,
  localparam int AW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           cclk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic [NCH-1:0] trig,
  input  logic           stop,
  input  logic           snooze,
  output logic           loud,
  output logic           busy,
  output logic [AW-1:0]  active_ch,
  output logic [NCH-1:0] pending
);

  typedef enum logic [1:0] {IDLE, ON, OFF, SNOOZE} state_t;

  localparam logic [CNT_W-1:0] DUR_LD = CNT_W'(DURATION);
  localparam logic [CNT_W-1:0] ON_LD  = CNT_W'(ON_TICKS);
  localparam logic [CNT_W-1:0] OFF_LD = CNT_W'(OFF_TICKS);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] dur_q, dur_d, ph_q, ph_d;
  logic [AW-1:0]    ch_d;
  logic [NCH-1:0]   pend_d, trig_q, rise, others;
  logic             armed_q, loud_d, busy_d;

`ifdef RING_SNOOZE_EN
  localparam logic [CNT_W-1:0] SNZ_LD = CNT_W'(SNOOZE_TICKS);
`else
  logic [CNT_W:0] snz_unused;
  assign snz_unused = {snooze, CNT_W'(SNOOZE_TICKS)};
`endif

  function automatic logic [AW-1:0] lowest(input logic [NCH-1:0] v);
    lowest = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (v[i]) lowest = AW'(i);
  endfunction

  // armed_q blocks the first post-reset cycle so a level already high is not seen as an edge
  assign rise   = armed_q ? (trig & ~trig_q) : '0;
  assign others = rise & ~(NCH'(1) << active_ch);

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dur_q     <= '0;
      ph_q      <= '0;
      trig_q    <= '0;
      armed_q   <= 1'b0;
      loud      <= 1'b0;
      busy      <= 1'b0;
      active_ch <= '0;
      pending   <= '0;
    end else begin
      state_q   <= state_d;
      dur_q     <= dur_d;
      ph_q      <= ph_d;
      trig_q    <= trig;
      armed_q   <= 1'b1;
      loud      <= loud_d;
      busy      <= busy_d;
      active_ch <= ch_d;
      pending   <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    ph_d    = ph_q;
    ch_d    = active_ch;
    pend_d  = pending;
    case (state_q)
      IDLE: begin
        if (|rise) begin
          state_d = ON;
          dur_d   = DUR_LD;
          ph_d    = ON_LD;
          ch_d    = lowest(rise);
          pend_d  = rise & ~(NCH'(1) << lowest(rise));
        end
      end
      ON, OFF: begin
        if (stop) begin
          state_d = IDLE;
          pend_d  = '0;
        end
`ifdef RING_SNOOZE_EN
        else if (snooze) begin
          state_d = SNOOZE;
          ph_d    = SNZ_LD;
          pend_d  = pending | others;
        end
`endif
        else begin
          pend_d = pending | others;
          if (rise[active_ch]) begin
            state_d = ON;
            dur_d   = DUR_LD;
            ph_d    = ON_LD;
          end else if (tick) begin
            dur_d = dur_q - ONE;
            ph_d  = ph_q - ONE;
            if (dur_q == ONE) begin
              // hand straight over to the next queued channel, no idle gap
              if (|pend_d) begin
                state_d = ON;
                dur_d   = DUR_LD;
                ph_d    = ON_LD;
                ch_d    = lowest(pend_d);
                pend_d  = pend_d & ~(NCH'(1) << lowest(pend_d));
              end else begin
                state_d = IDLE;
              end
            end else if (ph_q == ONE) begin
              if (state_q == ON && OFF_TICKS != 0) begin
                state_d = OFF;
                ph_d    = OFF_LD;
              end else begin
                state_d = ON;
                ph_d    = ON_LD;
              end
            end
          end
        end
      end
`ifdef RING_SNOOZE_EN
      SNOOZE: begin
        if (stop) begin
          state_d = IDLE;
          pend_d  = '0;
        end else begin
          pend_d = pending | others;
          if (tick) begin
            ph_d = ph_q - ONE;
            if (ph_q == ONE) begin
              state_d = ON;
              dur_d   = DUR_LD;
              ph_d    = ON_LD;
            end
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    loud_d = (state_d == ON);
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_ring_ctrl.sv
// Scoreboard bench for ring_ctrl: default instance plus a cadence instance (ON=2, OFF=1, DURATION=6).
module tb_ring_ctrl;

  logic       cclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] trig = 2'b00;
  logic       stop = 1'b0;
  logic       snooze = 1'b0;
  logic       loud, busy;
  logic [0:0] active_ch;
  logic [1:0] pending;

  logic [1:0] trig2 = 2'b00;
  logic       stop2 = 1'b0;
  logic       snooze2 = 1'b0;
  logic       loud2, busy2;
  logic [0:0] ach2;
  logic [1:0] pend2;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string tag;
    int    idx;
    bit    inst;
    bit    loud;
    bit    busy;
    int    ach;
    int    pend;
  } exp_t;

  exp_t sbq[$];

  ring_ctrl dut (
    .cclk(cclk), .rst_n(rst_n), .tick(tick), .trig(trig), .stop(stop), .snooze(snooze),
    .loud(loud), .busy(busy), .active_ch(active_ch), .pending(pending)
  );

  ring_ctrl #(.DURATION(6), .ON_TICKS(2), .OFF_TICKS(1)) dut2 (
    .cclk(cclk), .rst_n(rst_n), .tick(tick), .trig(trig2), .stop(stop2), .snooze(snooze2),
    .loud(loud2), .busy(busy2), .active_ch(ach2), .pending(pend2)
  );

  always #5 cclk = ~cclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    if (obs != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input string tag, input int idx, input bit inst,
                              input bit l, input bit b, input int a, input int p);
    exp_t e;
    e.tag = tag; e.idx = idx; e.inst = inst;
    e.loud = l; e.busy = b; e.ach = a; e.pend = p;
    return e;
  endfunction

  task automatic cmp_exp(input exp_t e);
    if (!e.inst) begin
      chk($sformatf("%s.loud@%0d", e.tag, e.idx), int'(loud), int'(e.loud));
      chk($sformatf("%s.busy@%0d", e.tag, e.idx), int'(busy), int'(e.busy));
      if (e.ach >= 0)  chk($sformatf("%s.ach@%0d", e.tag, e.idx), int'(active_ch), e.ach);
      if (e.pend >= 0) chk($sformatf("%s.pend@%0d", e.tag, e.idx), int'(pending), e.pend);
    end else begin
      chk($sformatf("%s.loud2@%0d", e.tag, e.idx), int'(loud2), int'(e.loud));
      chk($sformatf("%s.busy2@%0d", e.tag, e.idx), int'(busy2), int'(e.busy));
    end
  endtask

  // inputs are set by the caller before this; one clock edge is applied, then results are compared
  task automatic cycle(input exp_t e);
    sbq.push_back(e);
    @(negedge cclk);
    cmp_exp(sbq.pop_front());
  endtask

  initial begin
    int nt;
    bit pat [7];
    bit l, b;
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // reset state
    @(negedge cclk);
    cycle(mk("rst", 0, 0, 0, 0, 0, 0));
    cycle(mk("rst2", 0, 1, 0, 0, 0, 0));
    rst_n = 1'b1;
    cycle(mk("idle", 0, 0, 0, 0, 0, 0));

    // single ring, continuous tone, tick every 10 cycles, held level must not retrigger
    nt = 0;
    trig = 2'b01;
    for (int c = 0; c < 50; c++) begin
      tick = (c % 10 == 9);
      if (tick) nt++;
      cycle(mk("basic", c, 0, nt < 4, nt < 4, (nt < 4) ? 0 : -1, 0));
    end
    tick = 1'b0; trig = 2'b00;
    cycle(mk("basic_end", 0, 0, 0, 0, -1, 0));

    // cadence instance: per-tick pattern 1,1,0,1,1,0 then idle
    nt = 0;
    trig2 = 2'b01;
    for (int c = 0; c < 30; c++) begin
      tick = (c % 4 == 3);
      if (tick) nt++;
      cycle(mk("cad", c, 1, pat[(nt < 6) ? nt : 6], nt < 6, -1, -1));
    end
    tick = 1'b0; trig2 = 2'b00;
    cycle(mk("cad_end", 0, 1, 0, 0, -1, -1));

    // coincident edges: ch0 first, ch1 queued then served with no gap
    nt = 0;
    trig = 2'b11;
    for (int c = 0; c < 45; c++) begin
      tick = (c % 5 == 4);
      if (tick) nt++;
      if (nt < 4)      cycle(mk("multi", c, 0, 1, 1, 0, 2));
      else if (nt < 8) cycle(mk("multi", c, 0, 1, 1, 1, 0));
      else             cycle(mk("multi", c, 0, 0, 0, -1, 0));
    end
    tick = 1'b0; trig = 2'b00;
    cycle(mk("multi_end", 0, 0, 0, 0, -1, 0));

    // stop wins over a simultaneous ch1 edge; stop/snooze ignored in idle
    trig = 2'b01;
    for (int c = 0; c < 3; c++) cycle(mk("stop", c, 0, 1, 1, 0, 0));
    trig = 2'b11; stop = 1'b1;
    cycle(mk("stop", 3, 0, 0, 0, -1, 0));
    stop = 1'b0;
    for (int c = 4; c < 15; c++) begin
      tick = (c % 5 == 4);
      stop = (c == 8); snooze = (c == 8);
      cycle(mk("stop", c, 0, 0, 0, -1, 0));
    end
    tick = 1'b0; stop = 1'b0; snooze = 1'b0; trig = 2'b00;
    cycle(mk("stop_end", 0, 0, 0, 0, -1, 0));

    // snooze after two ticks
    nt = 0;
    trig = 2'b01;
    for (int c = 0; c < 75; c++) begin
      tick = (c % 5 == 4);
      snooze = (c == 10);
      if (tick) nt++;
`ifdef RING_SNOOZE_EN
      l = (c < 10) || (nt >= 10 && nt < 14);
      b = nt < 14;
`else
      l = nt < 4;
      b = nt < 4;
`endif
      cycle(mk("snz", c, 0, l, b, b ? 0 : -1, 0));
    end
    tick = 1'b0; snooze = 1'b0; trig = 2'b00;
    cycle(mk("snz_end", 0, 0, 0, 0, -1, 0));

    // asynchronous reset mid-ring, then a level held across release must not ring
    trig = 2'b01;
    cycle(mk("arst", 0, 0, 1, 1, 0, 0));
    #2;
    rst_n = 1'b0;
    sbq.push_back(mk("arst_async", 0, 0, 0, 0, 0, 0));
    #1;
    cmp_exp(sbq.pop_front());
    @(negedge cclk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick = (c % 5 == 4);
      cycle(mk("held", c, 0, 0, 0, 0, 0));
    end
    tick = 1'b0; trig = 2'b00;
    cycle(mk("rearm", 0, 0, 0, 0, 0, 0));
    trig = 2'b01;
    cycle(mk("rearm", 1, 0, 1, 1, 0, 0));
    trig = 2'b00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
